// File: rtl/pipe_ctrl_if.sv
// Hazard request inputs and stage enable/flush controls exchanged between
// the pipeline and its central controller.
interface pipe_ctrl_if;
    logic ld_stall_req_i;
    logic br_taken_i;
    logic mem_access_i;
    logic dmem_ready_i;
    logic pc_en_o;
    logic ifid_en_o;
    logic idex_en_o;
    logic exmem_en_o;
    logic memwb_en_o;
    logic ifid_flush_o;
    logic idex_flush_o;

    modport slave (
        input  ld_stall_req_i, br_taken_i, mem_access_i, dmem_ready_i,
        output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
               ifid_flush_o, idex_flush_o
    );

    modport master (
        output ld_stall_req_i, br_taken_i, mem_access_i, dmem_ready_i,
        input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
               ifid_flush_o, idex_flush_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: turns load-use, branch and data-memory hazards into
// synchronous stage enables/bubbles, with memory-timeout fault and event counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_ctrl_if.slave       pipe,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_o,
    output logic             fault_o
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic mem_wait;
    logic decide, ld_allow;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush;
    logic flush_evt, stall_evt;

    assign mem_wait = pipe.mem_access_i & ~pipe.dmem_ready_i;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        decide     = 1'b0;
        ld_allow   = 1'b0;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        flush_evt  = 1'b0;

        unique case (state_q)
            RUN: begin
                decide   = 1'b1;
                ld_allow = 1'b1;
            end
            LDSTALL: begin
                decide = 1'b1;
            end
            MEMWAIT: begin
                if (pipe.dmem_ready_i) begin
                    // Release cycle: full decision, load-use stall allowed again.
                    decide   = 1'b1;
                    ld_allow = 1'b1;
                    wait_d   = '0;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                    if (wait_d == TIMEOUT_V) begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (decide) begin
            if (mem_wait) begin
                state_d = MEMWAIT;
                wait_d  = WAIT_ONE;
            end else if (pipe.br_taken_i) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_evt  = 1'b1;
                state_d    = RUN;
            end else if (pipe.ld_stall_req_i && ld_allow) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
                state_d    = LDSTALL;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                state_d  = RUN;
            end
        end
    end

    assign stall_evt = ~pc_en & (state_q != FAULT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    // Reset must hold every stage frozen, independent of hazard inputs.
    assign pipe.pc_en_o      = pc_en      & ~rst_i;
    assign pipe.ifid_en_o    = ifid_en    & ~rst_i;
    assign pipe.idex_en_o    = idex_en    & ~rst_i;
    assign pipe.exmem_en_o   = exmem_en   & ~rst_i;
    assign pipe.memwb_en_o   = memwb_en   & ~rst_i;
    assign pipe.ifid_flush_o = ifid_flush & ~rst_i;
    assign pipe.idex_flush_o = idex_flush & ~rst_i;

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign state_o     = state_q;
    assign fault_o     = (state_q == FAULT);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table on a default instance, corner
// sequences and a randomized reference-model run on a small instance.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_s;
    pipe_ctrl_if pif ();
    pipe_ctrl_if sif ();

    logic [15:0] m_stall, m_flush;
    logic [1:0]  m_state;
    logic        m_fault;
    logic [3:0]  s_stall, s_flush;
    logic [1:0]  s_state;
    logic        s_fault;

    pipe_ctrl u_main (
        .clk_i      (clk),
        .rst_i      (rst_m),
        .pipe       (pif),
        .stall_cnt_o(m_stall),
        .flush_cnt_o(m_flush),
        .state_o    (m_state),
        .fault_o    (m_fault)
    );

    pipe_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) u_small (
        .clk_i      (clk),
        .rst_i      (rst_s),
        .pipe       (sif),
        .stall_cnt_o(s_stall),
        .flush_cnt_o(s_flush),
        .state_o    (s_state),
        .fault_o    (s_fault)
    );

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    logic [6:0] m_en, s_en;
    assign m_en = {pif.pc_en_o, pif.ifid_en_o, pif.idex_en_o, pif.exmem_en_o,
                   pif.memwb_en_o, pif.ifid_flush_o, pif.idex_flush_o};
    assign s_en = {sif.pc_en_o, sif.ifid_en_o, sif.idex_en_o, sif.exmem_en_o,
                   sif.memwb_en_o, sif.ifid_flush_o, sif.idex_flush_o};

    localparam logic [6:0] EN_NONE  = 7'b0000000;
    localparam logic [6:0] EN_ALL   = 7'b1111100;
    localparam logic [6:0] EN_FLUSH = 7'b1111111;
    localparam logic [6:0] EN_BUB   = 7'b0011101;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // inputs packed as {ld, br, mem_access, dmem_ready}
    task automatic drive_m(input logic [3:0] v);
        pif.ld_stall_req_i = v[3];
        pif.br_taken_i     = v[2];
        pif.mem_access_i   = v[1];
        pif.dmem_ready_i   = v[0];
    endtask

    task automatic drive_s(input logic [3:0] v);
        sif.ld_stall_req_i = v[3];
        sif.br_taken_i     = v[2];
        sif.mem_access_i   = v[1];
        sif.dmem_ready_i   = v[0];
    endtask

    // One small-instance cycle: drive at negedge, settle past posedge.
    task automatic s_cycle(input logic [3:0] v);
        drive_s(v);
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] in;
        logic [6:0] en;
        logic [1:0] st;
        int         stall;
        int         flush;
    } vec_t;

    vec_t tbl[17];

    int ms, mw, mst, mfl, ns;
    logic [6:0] e;
    logic r, dec, ld_ok, w;
    logic [3:0] v;

    initial begin
        tbl[0]  = '{4'b0000, EN_ALL,   2'd0, 0,  0};
        tbl[1]  = '{4'b1000, EN_BUB,   2'd1, 1,  0};
        tbl[2]  = '{4'b1000, EN_ALL,   2'd0, 1,  0};
        tbl[3]  = '{4'b1100, EN_FLUSH, 2'd0, 1,  1};
        tbl[4]  = '{4'b0010, EN_NONE,  2'd2, 2,  1};
        tbl[5]  = '{4'b0010, EN_NONE,  2'd2, 3,  1};
        tbl[6]  = '{4'b0010, EN_NONE,  2'd2, 4,  1};
        tbl[7]  = '{4'b0010, EN_NONE,  2'd2, 5,  1};
        tbl[8]  = '{4'b0010, EN_NONE,  2'd2, 6,  1};
        tbl[9]  = '{4'b0011, EN_ALL,   2'd0, 6,  1};
        tbl[10] = '{4'b0110, EN_NONE,  2'd2, 7,  1};
        tbl[11] = '{4'b0100, EN_NONE,  2'd2, 8,  1};
        tbl[12] = '{4'b0101, EN_FLUSH, 2'd0, 8,  2};
        tbl[13] = '{4'b0010, EN_NONE,  2'd2, 9,  2};
        tbl[14] = '{4'b1001, EN_BUB,   2'd1, 10, 2};
        tbl[15] = '{4'b1000, EN_ALL,   2'd0, 10, 2};
        tbl[16] = '{4'b0011, EN_ALL,   2'd0, 10, 2};

        rst_m = 1'b1;
        rst_s = 1'b1;
        drive_m(4'b0100);
        drive_s(4'b0000);
        #3;
        chk("rst_forced_en", 32'(m_en), 32'(EN_NONE));
        chk("rst_state", 32'(m_state), 0);
        chk("rst_stall", 32'(m_stall), 0);
        chk("rst_flush", 32'(m_flush), 0);
        chk("rst_fault", 32'(m_fault), 0);
        @(negedge clk);
        rst_m = 1'b0;
        rst_s = 1'b0;

        // Directed vector table, continuous from reset.
        for (int i = 0; i < 17; i++) begin
            drive_m(tbl[i].in);
            #2;
            chk($sformatf("vec%0d_en", i), 32'(m_en), 32'(tbl[i].en));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_state", i), 32'(m_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_stall", i), 32'(m_stall), 32'(tbl[i].stall));
            chk($sformatf("vec%0d_flush", i), 32'(m_flush), 32'(tbl[i].flush));
            chk($sformatf("vec%0d_fault", i), 32'(m_fault), 0);
            @(negedge clk);
        end

        // Timeout: four wait cycles with MEM_TIMEOUT=4 land in FAULT.
        for (int i = 0; i < 3; i++) s_cycle(4'b0010);
        chk("to_wait_state", 32'(s_state), 2);
        chk("to_wait_fault", 32'(s_fault), 0);
        s_cycle(4'b0010);
        chk("to_fault_state", 32'(s_state), 3);
        chk("to_fault_flag", 32'(s_fault), 1);
        chk("to_stall", 32'(s_stall), 4);
        drive_s(4'b0101);
        #2;
        chk("fault_en", 32'(s_en), 32'(EN_NONE));
        @(posedge clk);
        #1;
        chk("fault_sticky", 32'(s_state), 3);
        chk("fault_no_flush", 32'(s_flush), 0);
        chk("fault_no_stall", 32'(s_stall), 4);
        @(posedge clk);
        #3;
        rst_s = 1'b1;
        #1;
        chk("async_rst_state", 32'(s_state), 0);
        chk("async_rst_fault", 32'(s_fault), 0);
        chk("async_rst_stall", 32'(s_stall), 0);
        @(negedge clk);
        rst_s = 1'b0;

        // Counter saturation on the 4-bit instance.
        for (int i = 0; i < 10; i++) s_cycle(4'b0100);
        chk("sat_flush_10", 32'(s_flush), 10);
        for (int i = 0; i < 10; i++) s_cycle(4'b0100);
        chk("sat_flush_20", 32'(s_flush), 15);
        for (int i = 0; i < 40; i++) s_cycle(4'b1000);
        chk("sat_stall_20", 32'(s_stall), 15);
        chk("sat_state", 32'(s_state), 0);

        // Randomized run against a spec-level model.
        rst_s = 1'b1;
        drive_s(4'b0000);
        @(negedge clk);
        ms = 0; mw = 0; mst = 0; mfl = 0;
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 99) == 0);
            v = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            rst_s = r;
            drive_s(v);
            e = EN_NONE;
            if (r) begin
                ms = 0; mw = 0; mst = 0; mfl = 0;
            end else begin
                w     = v[1] & ~v[0];
                dec   = 1'b0;
                ld_ok = 1'b0;
                ns    = ms;
                if (ms == 0) begin
                    dec = 1'b1; ld_ok = 1'b1;
                end else if (ms == 1) begin
                    dec = 1'b1;
                end else if (ms == 2) begin
                    if (v[0]) begin
                        dec = 1'b1; ld_ok = 1'b1; mw = 0;
                    end else begin
                        mw++;
                        if (mw == 4) ns = 3;
                    end
                end
                if (dec) begin
                    if (w) begin
                        ns = 2; mw = 1;
                    end else if (v[2]) begin
                        e = EN_FLUSH; ns = 0;
                        if (mfl < 15) mfl++;
                    end else if (v[3] && ld_ok) begin
                        e = EN_BUB; ns = 1;
                    end else begin
                        e = EN_ALL; ns = 0;
                    end
                end
                if (ms != 3 && !e[6] && mst < 15) mst++;
                ms = ns;
            end
            #2;
            chk("rnd_en", 32'(s_en), 32'(e));
            @(posedge clk);
            #1;
            chk("rnd_state", 32'(s_state), 32'(ms));
            chk("rnd_stall", 32'(s_stall), 32'(mst));
            chk("rnd_flush", 32'(s_flush), 32'(mfl));
            chk("rnd_fault", 32'(s_fault), 32'(ms == 3));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage RISC-V core. It takes hazard requests from the ID-stage load-use detector, the EX-stage branch resolver and the MEM-stage data-memory handshake. From these it drives clock-enable and flush (bubble) controls for the PC and every pipeline register, replacing gated-clock stalling with synchronous enables. A small FSM enforces single-cycle load-use stalls, freezes the pipeline on memory wait with a timeout fault, and keeps saturating stall/flush event counters.

## Interface
- CNT_W, 16: width of stall/flush counters
- MEM_TIMEOUT, 64: max consecutive memory-wait cycles before fault (>=2)

- clk_i  in  1  single core clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- ld_stall_req_i  in  1  load-use hazard detected for instruction in ID
- br_taken_i  in  1  branch/jump resolved taken in EX
- mem_access_i  in  1  MEM stage holds a load/store
- dmem_ready_i  in  1  data memory completes access this cycle
- pc_en_o  out  1  PC update enable
- ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  pipeline register enables
- ifid_flush_o, idex_flush_o  out  1 each  load NOP/bubble into register (only meaningful with its enable high)
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0 (excluding reset/FAULT)
- flush_cnt_o  out  CNT_W  taken-branch flush events
- state_o  out  2  FSM state: RUN=0, LDSTALL=1, MEMWAIT=2, FAULT=3
- fault_o  out  1  sticky memory-timeout fault

## Operation
- Memory wait condition W = mem_access_i & ~dmem_ready_i. Priority: W > br_taken_i > ld_stall_req_i.
- Decision in RUN and LDSTALL, and in MEMWAIT once dmem_ready_i=1:
  - W: all enables 0, flushes 0; next MEMWAIT; wait counter loads 1.
  - else br_taken_i: all enables 1, ifid_flush_o=idex_flush_o=1; flush_cnt_o +1; next RUN.
  - else ld_stall_req_i, state≠LDSTALL: pc_en_o=ifid_en_o=0; idex_en_o=1 with idex_flush_o=1 (bubble); exmem/memwb enables 1; next LDSTALL.
  - else: all enables 1, flushes 0; next RUN.
- In LDSTALL, ld_stall_req_i is ignored. This guarantees exactly one bubble per load and no livelock.
- In MEMWAIT with dmem_ready_i=0: all enables 0, flushes 0. Wait counter increments. When the counter reaches MEM_TIMEOUT, the next state is FAULT.
- When MEMWAIT sees dmem_ready_i=1, it applies the decision above in the same cycle, with LDSTALL treated as not current. The wait counter clears.
- FAULT: all enables 0, flushes 0, fault_o=1. Inputs are ignored. Only rst_i exits.
- stall_cnt_o increments on every cycle with pc_en_o=0 in RUN/LDSTALL/MEMWAIT. Both counters saturate at 2^CNT_W-1.
- Wait counter width is clog2(MEM_TIMEOUT+1), internal.

## Timing
- Enables and flushes are combinational from state and the current inputs (zero-cycle latency). They are valid before the rising edge that they qualify.
- State, counters and fault_o update on the rising clk_i edge.
- Reset (async, immediate): state RUN, counters 0, wait counter 0, fault_o 0. While rst_i=1, all enables and flushes are forced 0.
- A branch coinciding with a load-use request: the branch wins, no bubble is inserted, and the state goes to RUN. The flushed ID instruction makes the stall moot.
- A branch during W: frozen. EX holds the branch and re-presents br_taken_i after release, so the flush occurs on the release cycle.
- Load-use request held for two consecutive cycles: the first cycle stalls; the second (state LDSTALL) proceeds with all enables 1.
- Reset mid-MEMWAIT or in FAULT: returns to RUN immediately, and counters clear.

## Test plan
- Reset, then all inputs 0 → all enables 1, flushes 0, state_o=0, counters 0.
- ld_stall_req_i=1 for 2 cycles → cycle 1: pc_en/ifid_en=0, idex_flush=1, state→1; cycle 2: all enables 1, state→0; stall_cnt_o=1.
- br_taken_i=1 together with ld_stall_req_i=1 → ifid_flush=idex_flush=1, pc_en=1, flush_cnt_o=1, stall_cnt_o=0, state stays 0.
- mem_access_i=1 with dmem_ready_i=0 for 5 cycles, then 1 → all enables 0 for 5 cycles, stall_cnt_o=5, state_o=2, then enables 1 and state 0.
- MEM_TIMEOUT=4 with dmem_ready_i held 0 → FAULT entered after 4 wait cycles, fault_o=1, enables 0. Asserting rst_i asynchronously mid-cycle clears fault_o and state_o at once.
- flush_cnt_o preset near saturation (CNT_W=4, 20 branches) → holds at 15.
